// File: rtl/video_frame_reader.sv
// Avalon-MM burst read master: fetches one frame from memory in credit-limited
// bursts and replays it as a valid/ready pixel stream with sop/eop markers.
module video_frame_reader #(
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 256,
  parameter int CNT_W      = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      frame_base,
  input  logic [CNT_W-1:0] frame_words,
  output logic             busy,
  output logic             done,
  output logic [31:0]      avm_address,
  output logic             avm_read,
  output logic [8:0]       avm_burstcount,
  output logic [3:0]       avm_byteenable,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid,
  output logic [31:0]      st_data,
  output logic             st_valid,
  input  logic             st_ready,
  output logic             st_sop,
  output logic             st_eop
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [OW-1:0]    DEPTH_OW  = OW'(FIFO_DEPTH);

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] req_left_q, req_left_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic [OW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             done_q, done_d;
  logic [31:0]      mem [FIFO_DEPTH];

  logic [CNT_W-1:0] burst;
  logic [OW-1:0]    credit;
  logic             req_accept, push, pop;

  // Credit only grows while a request is stalled (pushes trade outstanding for
  // count, pops free space), so avm_read stays high until accepted.
  assign burst          = (req_left_q > BURST_CNT) ? BURST_CNT : req_left_q;
  assign credit         = DEPTH_OW - count_q - outst_q;
  assign avm_read       = (state_q == S_REQ) && (credit >= OW'(burst));
  assign avm_burstcount = (state_q == S_REQ) ? 9'(burst) : 9'd0;
  assign avm_address    = addr_q;
  assign avm_byteenable = 4'hF;
  assign req_accept     = avm_read && !avm_waitrequest;
  assign push           = avm_readdatavalid && (state_q != S_IDLE);

  assign st_valid = (count_q != '0);
  assign st_data  = mem[rd_ptr_q];
  assign st_sop   = st_valid && (out_idx_q == '0);
  assign st_eop   = st_valid && (out_idx_q == words_q - CNT_W'(1));
  assign pop      = st_valid && st_ready;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    req_left_d = req_left_q;
    words_d    = words_q;
    out_idx_d  = pop ? out_idx_q + CNT_W'(1) : out_idx_q;
    done_d     = 1'b0;
    outst_d    = outst_q + (req_accept ? OW'(burst) : '0) - (push ? OW'(1) : '0);
    count_d    = count_q + OW'(push) - OW'(pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = frame_base;
          words_d    = frame_words;
          req_left_d = frame_words;
          out_idx_d  = '0;
          if (frame_words == '0) done_d  = 1'b1;
          else                   state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (req_accept) begin
          addr_d     = addr_q + (32'(burst) << 2);
          req_left_d = req_left_q - burst;
          if (req_left_q == burst) state_d = S_DRAIN;
        end
      end
      default: ;
    endcase

    if (busy && pop && st_eop) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      req_left_q <= '0;
      words_q    <= '0;
      out_idx_q  <= '0;
      outst_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_left_q <= req_left_d;
      words_q    <= words_d;
      out_idx_q  <= out_idx_d;
      outst_q    <= outst_d;
      count_q    <= count_d;
      done_q     <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // NOTE: the storage array is not reset; emptiness is tracked by count_q alone,
  // which keeps the array mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= avm_readdata;
  end
endmodule

// File: tb/tb_video_frame_reader.sv
// Self-checking bench for video_frame_reader: Avalon slave model, frame-level
// reference model and a per-cycle compare process.
module tb_video_frame_reader;
  localparam int BURST_LEN  = 64;
  localparam int FIFO_DEPTH = 256;
  localparam int CNT_W      = 24;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      frame_base;
  logic [CNT_W-1:0] frame_words;
  logic             busy, done;
  logic [31:0]      avm_address;
  logic             avm_read;
  logic [8:0]       avm_burstcount;
  logic [3:0]       avm_byteenable;
  logic             avm_waitrequest;
  logic [31:0]      avm_readdata;
  logic             avm_readdatavalid;
  logic [31:0]      st_data;
  logic             st_valid, st_ready, st_sop, st_eop;

  always #5 clk = ~clk;

  video_frame_reader #(.BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_base(frame_base),
    .frame_words(frame_words), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .st_sop(st_sop), .st_eop(st_eop)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: a bijective function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model state
  logic [31:0] exp_data[$];
  logic [31:0] exp_req_addr[$];
  int          exp_req_cnt[$];
  logic [31:0] log_addr[$];
  int          log_cnt[$];
  int          exp_n, exp_idx;
  int          words_requested, words_popped, done_count, stall_cycles;

  // Slave / sink controls
  logic [31:0] pend[$];
  int          stall_budget = 0;
  bit          gap_mode = 0;
  int          ready_mode = 0;
  int          cyc = 0;

  task automatic start_frame(input logic [31:0] base, input int n, input logic [31:0] st_words);
    exp_data.delete();
    exp_req_addr.delete();
    exp_req_cnt.delete();
    log_addr.delete();
    log_cnt.delete();
    for (int i = 0; i < n; i++) exp_data.push_back(mem_word(base + 32'(i * 4)));
    for (int k = 0; k * BURST_LEN < n; k++) begin
      exp_req_addr.push_back(base + 32'(k * BURST_LEN * 4));
      exp_req_cnt.push_back((n - k * BURST_LEN > BURST_LEN) ? BURST_LEN : n - k * BURST_LEN);
    end
    exp_n = n; exp_idx = 0;
    words_requested = 0; words_popped = 0; done_count = 0; stall_cycles = 0;
    @(posedge clk); #1;
    frame_base  = base;
    frame_words = CNT_W'(st_words);
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    check({name, "_done_seen"}, got, 1);
    repeat (4) @(negedge clk);
    check({name, "_done_count"}, done_count, 1);
    check({name, "_words_popped"}, words_popped, exp_n);
    check({name, "_busy_after"}, busy, 0);
  endtask

  // Avalon slave (1-cycle min latency, optional gaps) and stream sink driver
  initial begin
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0; st_ready = 1;
    forever begin
      @(negedge clk);
      if (reset) pend.delete();
      else if (avm_read && !avm_waitrequest)
        for (int i = 0; i < int'(avm_burstcount); i++) pend.push_back(avm_address + 32'(i * 4));
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        pend.delete();
        avm_readdatavalid = 0;
        avm_waitrequest   = 0;
      end else begin
        avm_waitrequest = avm_read && (stall_budget > 0);
        if (avm_waitrequest) stall_budget--;
        if (pend.size() > 0 && !(gap_mode && (cyc % 3 == 0))) begin
          avm_readdatavalid = 1;
          avm_readdata      = mem_word(pend.pop_front());
        end else begin
          avm_readdatavalid = 0;
          avm_readdata      = '0;
        end
      end
      st_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : ((cyc % 4) != 0);
    end
  end

  // Per-cycle compare against the frame-level model
  initial begin
    logic        pend_done, nd, prev_stall, prev_hold;
    logic [31:0] prev_addr, prev_data;
    logic [8:0]  prev_bc;
    pend_done = 0; prev_stall = 0; prev_hold = 0;
    prev_addr = '0; prev_data = '0; prev_bc = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend_done = 0; prev_stall = 0; prev_hold = 0;
      end else begin
        nd = 0;
        check("done_pulse", done, pend_done);
        if (done) done_count++;
        if (start && !busy && frame_words == '0) nd = 1;
        if (prev_stall) begin
          check("stall_read_held", avm_read, 1);
          check("stall_addr_held", avm_address, prev_addr);
          check("stall_bc_held", avm_burstcount, prev_bc);
        end
        if (avm_read && avm_waitrequest) stall_cycles++;
        if (prev_hold) begin
          check("st_valid_held", st_valid, 1);
          check("st_data_held", st_data, prev_data);
        end
        if (avm_read && !avm_waitrequest) begin
          if (exp_req_addr.size() == 0) check("unexpected_request", 1, 0);
          else begin
            check("req_addr", avm_address, exp_req_addr.pop_front());
            check("req_burstcount", avm_burstcount, exp_req_cnt.pop_front());
          end
          log_addr.push_back(avm_address);
          log_cnt.push_back(int'(avm_burstcount));
          words_requested += int'(avm_burstcount);
          check("credit_bound", (words_requested - words_popped) <= FIFO_DEPTH, 1);
        end
        if (st_valid && st_ready) begin
          if (exp_data.size() == 0) check("extra_stream_word", 1, 0);
          else begin
            check("st_data", st_data, exp_data.pop_front());
            check("st_sop", st_sop, exp_idx == 0);
            check("st_eop", st_eop, exp_idx == exp_n - 1);
            if (exp_idx == exp_n - 1) nd = 1;
            exp_idx++;
            words_popped++;
          end
        end
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
        prev_bc    = avm_burstcount;
        prev_hold  = st_valid && !st_ready;
        prev_data  = st_data;
        pend_done  = nd;
      end
    end
  end

  initial begin
    reset = 1; start = 0; frame_base = '0; frame_words = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read", avm_read, 0);
    check("rst_addr", avm_address, 0);
    check("rst_bc", avm_burstcount, 0);
    check("rst_byteenable", avm_byteenable, 4'hF);
    check("rst_st_valid", st_valid, 0);
    check("rst_sop_eop", {st_sop, st_eop}, 2'b00);
    @(posedge clk); #1 reset = 0;

    // 128 words, two full bursts, no stalls
    start_frame(32'h1000_0000, 128, 128);
    wait_done("f128");
    check("f128_nreq", log_addr.size(), 2);
    check("f128_addr1", log_addr[1], 32'h1000_0100);
    check("f128_cnt0", log_cnt[0], 64);
    check("f128_cnt1", log_cnt[1], 64);

    // 100 words: partial second burst, gaps and a throttled sink
    gap_mode = 1; ready_mode = 2;
    start_frame(32'h2000_0040, 100, 100);
    wait_done("f100");
    check("f100_addr1", log_addr[1], 32'h2000_0140);
    check("f100_cnt1", log_cnt[1], 36);
    gap_mode = 0; ready_mode = 0;

    // waitrequest stalls the first request for 5 cycles
    stall_budget = 5;
    start_frame(32'h3000_0000, 128, 128);
    wait_done("stall");
    check("stall_cycles", stall_cycles, 5);

    // sink blocked for 1000 cycles: exactly one FIFO's worth requested
    ready_mode = 1;
    start_frame(32'h4000_0000, 600, 600);
    repeat (1000) @(posedge clk);
    #1;
    check("blocked_requested", words_requested, FIFO_DEPTH);
    check("blocked_popped", words_popped, 0);
    check("blocked_busy", busy, 1);
    ready_mode = 0;
    wait_done("blocked");

    // zero-length frame
    start_frame(32'h5000_0000, 0, 0);
    wait_done("zero");
    check("zero_nreq", log_addr.size(), 0);

    // single-word frame
    start_frame(32'h6000_0004, 1, 1);
    wait_done("one");
    check("one_cnt0", log_cnt[0], 1);

    // address wraps past 2^32
    start_frame(32'hFFFF_FF00, 128, 128);
    wait_done("wrap");
    check("wrap_addr1", log_addr[1], 32'h0000_0000);

    // start while busy is ignored
    start_frame(32'h7000_0000, 128, 128);
    repeat (3) @(posedge clk);
    #1 frame_base = 32'hDEAD_0000; frame_words = '0; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done("ignored_start");

    // reset in the middle of a burst, then a clean frame
    gap_mode = 1; ready_mode = 1;
    start_frame(32'h8000_0000, 256, 256);
    repeat (10) @(posedge clk);
    #3 reset = 1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_read", avm_read, 0);
    check("midrst_addr", avm_address, 0);
    check("midrst_bc", avm_burstcount, 0);
    check("midrst_st", {st_valid, st_sop, st_eop}, 3'b000);
    exp_data.delete(); exp_req_addr.delete(); exp_req_cnt.delete();
    gap_mode = 0; ready_mode = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    start_frame(32'h9000_0000, 128, 128);
    wait_done("after_rst");
    check("after_rst_addr0", log_addr[0], 32'h9000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
